// File: rtl/corr_accumulator_pkg.sv
// Shared acquire-engine constants, FSM encoding and the chip-count to
// correlation-value mapping used by the coherent accumulator.
package corr_accumulator_pkg;

  localparam int MATCH_BITS = 31;
  localparam int CNT_W      = 5;
  localparam int LEN_W      = 6;
  localparam int ACC_W      = 12;
  localparam int MAG_W      = 11;
  localparam int IDX_W      = 10;

  typedef enum logic {
    ST_IDLE  = 1'b0,  // no partial sum held
    ST_ACCUM = 1'b1   // partial sum held in acc
  } state_e;

  // Map a matching-chip count to its correlation value 2*cnt - 31
  // (range -31..+31), returned already sign-extended to the accumulator width.
  function automatic logic signed [ACC_W-1:0] chip_sum(input logic [CNT_W-1:0] cnt);
    logic signed [ACC_W-1:0] twice;
    twice = $signed({{(ACC_W-CNT_W-1){1'b0}}, cnt, 1'b0});
    return twice - $signed(ACC_W'(MATCH_BITS));
  endfunction

endpackage

// File: rtl/corr_accumulator_peak_tracker.sv
// Tracks the largest |result| seen since clear/reset and the result index at
// which it was captured. Strictly-greater comparison, so ties keep the
// earlier index.
module peak_tracker
  import corr_accumulator_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic signed [ACC_W-1:0] result,
  input  logic                    result_valid,
  input  logic [IDX_W-1:0]        result_index,
  output logic [MAG_W-1:0]        peak_mag,
  output logic [IDX_W-1:0]        peak_index
);

  logic [MAG_W-1:0] mag;
  logic [MAG_W-1:0] peak_mag_d, peak_mag_q;
  logic [IDX_W-1:0] peak_index_d, peak_index_q;

  // |result| fits in MAG_W bits (max 1984), so negate only the low bits.
  always_comb begin
    mag = result[ACC_W-1] ? (~result[MAG_W-1:0] + MAG_W'(1)) : result[MAG_W-1:0];
  end

  // Next peak: cleared on clear, captured on a strictly larger valid result.
  always_comb begin
    peak_mag_d   = peak_mag_q;
    peak_index_d = peak_index_q;
    if (clear) begin
      peak_mag_d   = '0;
      peak_index_d = '0;
    end else if (result_valid && (mag > peak_mag_q)) begin
      peak_mag_d   = mag;
      peak_index_d = result_index;
    end
  end

  // Peak registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      peak_mag_q   <= '0;
      peak_index_q <= '0;
    end else begin
      peak_mag_q   <= peak_mag_d;
      peak_index_q <= peak_index_d;
    end
  end

  assign peak_mag   = peak_mag_q;
  assign peak_index = peak_index_q;

endmodule

// File: rtl/corr_accumulator.sv
// Coherent correlation accumulator: sums (acc_length+1) segment values
// 2*match_cnt-31, emits each sum as a one-cycle result pulse with a running
// result index, and tracks the peak magnitude.
// Handshake: match_valid is a plain qualifier (no ready); every cycle with
// match_valid high and clear low is consumed. result_valid is a one-cycle
// pulse with no back-pressure.
module corr_accumulator
  import corr_accumulator_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic [LEN_W-1:0]        acc_length,
  input  logic                    match_valid,
  input  logic [CNT_W-1:0]        match_cnt,
  output logic                    result_valid,
  output logic signed [ACC_W-1:0] result,
  output logic [IDX_W-1:0]        result_index,
  output logic [MAG_W-1:0]        peak_mag,
  output logic [IDX_W-1:0]        peak_index,
  output state_e                  dbg_state
);

  state_e                  state_d, state_q;
  logic signed [ACC_W-1:0] acc_d, acc_q;
  logic [LEN_W-1:0]        seg_cnt_d, seg_cnt_q;
  logic [LEN_W-1:0]        len_d, len_q;
  logic signed [ACC_W-1:0] result_d, result_q;
  logic                    result_valid_d, result_valid_q;
  logic [IDX_W-1:0]        result_index_d, result_index_q;
  logic signed [ACC_W-1:0] sample;

  assign sample = chip_sum(match_cnt);

  // Next-state logic: clear beats match_valid; the final segment dumps acc+sample.
  always_comb begin
    state_d        = state_q;
    acc_d          = acc_q;
    seg_cnt_d      = seg_cnt_q;
    len_d          = len_q;
    result_d       = result_q;
    result_valid_d = 1'b0;
    // The index advances in the cycle after each pulse.
    result_index_d = result_valid_q ? (result_index_q + IDX_W'(1)) : result_index_q;

    if (clear) begin
      state_d        = ST_IDLE;
      acc_d          = '0;
      seg_cnt_d      = '0;
      result_index_d = '0;
    end else if (match_valid) begin
      unique case (state_q)
        ST_IDLE: begin
          len_d = acc_length;
          if (acc_length == '0) begin
            result_d       = sample;
            result_valid_d = 1'b1;
            acc_d          = '0;
            seg_cnt_d      = '0;
          end else begin
            acc_d     = sample;
            seg_cnt_d = LEN_W'(1);
            state_d   = ST_ACCUM;
          end
        end
        ST_ACCUM: begin
          if (seg_cnt_q == len_q) begin
            result_d       = acc_q + sample;
            result_valid_d = 1'b1;
            acc_d          = '0;
            seg_cnt_d      = '0;
            state_d        = ST_IDLE;
          end else begin
            acc_d     = acc_q + sample;
            seg_cnt_d = seg_cnt_q + LEN_W'(1);
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // FSM and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      acc_q          <= '0;
      seg_cnt_q      <= '0;
      len_q          <= '0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      result_index_q <= '0;
    end else begin
      state_q        <= state_d;
      acc_q          <= acc_d;
      seg_cnt_q      <= seg_cnt_d;
      len_q          <= len_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
      result_index_q <= result_index_d;
    end
  end

  peak_tracker u_peak (
    .clk          (clk),
    .rst          (rst),
    .clear        (clear),
    .result       (result_q),
    .result_valid (result_valid_q),
    .result_index (result_index_q),
    .peak_mag     (peak_mag),
    .peak_index   (peak_index)
  );

  assign result_valid = result_valid_q;
  assign result       = result_q;
  assign result_index = result_index_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_corr_accumulator.sv
// Directed bench for corr_accumulator with hand-computed expected results.
module tb_corr_accumulator;
  import corr_accumulator_pkg::*;

  logic                    clk;
  logic                    rst;
  logic                    clear;
  logic [LEN_W-1:0]        acc_length;
  logic                    match_valid;
  logic [CNT_W-1:0]        match_cnt;
  logic                    result_valid;
  logic signed [ACC_W-1:0] result;
  logic [IDX_W-1:0]        result_index;
  logic [MAG_W-1:0]        peak_mag;
  logic [IDX_W-1:0]        peak_index;
  state_e                  dbg_state;

  int n_checks;
  int n_errors;
  logic [ACC_W-1:0] exp_q[$];

  corr_accumulator dut (
    .clk          (clk),
    .rst          (rst),
    .clear        (clear),
    .acc_length   (acc_length),
    .match_valid  (match_valid),
    .match_cnt    (match_cnt),
    .result_valid (result_valid),
    .result       (result),
    .result_index (result_index),
    .peak_mag     (peak_mag),
    .peak_index   (peak_index),
    .dbg_state    (dbg_state)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  // One clock; outputs sampled 1ns after the edge. Any result pulse is
  // scored against the expected queue.
  task automatic step();
    @(posedge clk);
    #1;
    if (result_valid) begin
      if (exp_q.size() == 0) check("unexpected_result", 32'd1, 32'd0);
      else check("result", {20'd0, result}, {20'd0, exp_q.pop_front()});
    end
  endtask

  task automatic send(input logic [CNT_W-1:0] cnt);
    match_valid = 1'b1;
    match_cnt   = cnt;
    step();
    match_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_rv"},    {31'd0, result_valid}, 32'd0);
    check({tag, "_res"},   {20'd0, result},       32'd0);
    check({tag, "_idx"},   {22'd0, result_index}, 32'd0);
    check({tag, "_pmag"},  {21'd0, peak_mag},     32'd0);
    check({tag, "_pidx"},  {22'd0, peak_index},   32'd0);
  endtask

  initial begin
    n_checks    = 0;
    n_errors    = 0;
    rst         = 1'b1;
    clear       = 1'b0;
    acc_length  = '0;
    match_valid = 1'b0;
    match_cnt   = '0;

    // Reset state
    idle(2);
    check_zero_outputs("reset");
    rst = 1'b0;
    idle(1);

    // Single-segment result of +31
    acc_length = 6'd0;
    exp_q.push_back(12'd31);
    send(5'd31);
    check("t1_rv",  {31'd0, result_valid}, 32'd1);
    check("t1_idx_at_pulse", {22'd0, result_index}, 32'd0);
    idle(1);
    check("t1_rv_low", {31'd0, result_valid}, 32'd0);
    check("t1_pmag", {21'd0, peak_mag},     32'd31);
    check("t1_pidx", {22'd0, peak_index},   32'd0);
    check("t1_idx",  {22'd0, result_index}, 32'd1);

    // 64 segments of all-mismatch -> -1984 (0x840)
    do_clear();
    check("t2_idx_cleared", {22'd0, result_index}, 32'd0);
    acc_length = 6'd63;
    for (int i = 0; i < 63; i++) send(5'd0);
    check("t2_no_early_rv", {31'd0, result_valid}, 32'd0);
    exp_q.push_back(12'h840);
    send(5'd0);
    check("t2_rv", {31'd0, result_valid}, 32'd1);
    idle(1);
    check("t2_pmag", {21'd0, peak_mag}, 32'd1984);

    // Gaps between samples, acc_length changed mid-accumulation
    // 20->+9, 10->-11, 31->+31, 0->-31 : sum -2 (0xFFE)
    do_clear();
    acc_length = 6'd3;
    send(5'd20);
    acc_length = 6'd0;
    idle(2);
    send(5'd10);
    idle(3);
    send(5'd31);
    check("t3_no_early_rv", {31'd0, result_valid}, 32'd0);
    idle(1);
    exp_q.push_back(12'hFFE);
    send(5'd0);
    check("t3_rv", {31'd0, result_valid}, 32'd1);
    idle(1);
    check("t3_pmag", {21'd0, peak_mag}, 32'd2);

    // clear with the 3rd sample drops it; then 4 x 16 (+1 each) -> +4
    do_clear();
    acc_length = 6'd3;
    send(5'd16);
    send(5'd16);
    clear = 1'b1;
    send(5'd16);
    clear = 1'b0;
    check("t4_rv_clear", {31'd0, result_valid}, 32'd0);
    for (int i = 0; i < 3; i++) send(5'd16);
    exp_q.push_back(12'd4);
    send(5'd16);
    check("t4_rv",  {31'd0, result_valid}, 32'd1);
    check("t4_idx", {22'd0, result_index}, 32'd0);
    idle(1);
    check("t4_idx_after", {22'd0, result_index}, 32'd1);

    // Peak tracking with ties: +5, -5, +7, -7
    do_clear();
    acc_length = 6'd0;
    exp_q.push_back(12'd5);    send(5'd18);
    exp_q.push_back(12'hFFB);  send(5'd13);
    exp_q.push_back(12'd7);    send(5'd19);
    exp_q.push_back(12'hFF9);  send(5'd12);
    idle(1);
    check("t5_pmag", {21'd0, peak_mag},     32'd7);
    check("t5_pidx", {22'd0, peak_index},   32'd2);
    check("t5_idx",  {22'd0, result_index}, 32'd4);

    // Reset mid-accumulation discards the partial sum
    acc_length = 6'd3;
    send(5'd31);
    send(5'd31);
    rst = 1'b1;
    idle(1);
    check_zero_outputs("t6_rst");
    idle(1);
    check("t6_rst_state", {31'd0, dbg_state}, {31'd0, ST_IDLE});
    rst = 1'b0;
    for (int i = 0; i < 3; i++) send(5'd31);
    exp_q.push_back(12'd124);
    send(5'd31);
    check("t6_rv", {31'd0, result_valid}, 32'd1);
    idle(1);

    // clear coinciding with a dump produces no pulse
    acc_length = 6'd0;
    clear = 1'b1;
    send(5'd31);
    clear = 1'b0;
    check("t7_rv", {31'd0, result_valid}, 32'd0);
    idle(2);
    check("t7_idx", {22'd0, result_index}, 32'd0);

    check("exp_q_empty", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/corr_accumulator.md
CORR_ACCUMULATOR -- requirements
Module: corr_accumulator

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-high.
REQ-002 clk  input  1  clock; all state updates on its rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 clear  input  1  aborts the partial sum; zeroes result_index and peak state.
REQ-005 acc_length  input  6  segments per result minus one (0 -> 1 segment, 63 -> 64 segments).
REQ-006 match_valid  input  1  match_cnt valid this cycle.
REQ-007 match_cnt  input  5  count of matching chips in a 31-chip segment (0..31), from the 31-input popcount stage.
REQ-008 result_valid  output  1  one-cycle pulse; result and result_index valid.
REQ-009 result  output  12  signed coherent correlation sum.
REQ-010 result_index  output  10  ordinal of the current result since clear/reset.
REQ-011 peak_mag  output  11  largest |result| since clear/reset.
REQ-012 peak_index  output  10  result_index at which peak_mag was captured.

Function
REQ-013 Each accepted sample SHALL be mapped to d = 2*match_cnt - 31 (signed 7 bits, -31..+31).
REQ-014 The FSM SHALL have two states: IDLE (no partial sum) and ACCUM (partial sum held).
REQ-015 IDLE with match_valid: SHALL latch acc_length into len_q and set acc = d, seg_cnt = 1; go to ACCUM, or dump immediately (REQ-017) if acc_length = 0.
REQ-016 ACCUM with match_valid and seg_cnt != len_q: SHALL set acc += d and seg_cnt += 1.
REQ-017 Dump, on the final segment (seg_cnt = len_q): result <= acc + d; result_valid = 1 in the next cycle only; acc and seg_cnt <= 0; state <= IDLE.
REQ-018 Latency SHALL be one cycle from the final accepted match_valid to result_valid.
REQ-019 After each dump, result_index SHALL increment by one on the cycle after result_valid; it wraps 1023 -> 0.
REQ-020 acc_length changes while in ACCUM SHALL have no effect until the next IDLE start.
REQ-021 Accumulator width SHALL be 12 bits signed; maximum |sum| = 64*31 = 1984, so overflow is impossible and there is no saturation logic.
REQ-022 On each result_valid with |result| > peak_mag (strict), peak_mag and peak_index SHALL update in the same cycle that result_index advances; ties keep the earlier index.
REQ-023 Cycles without match_valid SHALL hold all state; gaps between segments are allowed.
REQ-024 clear SHALL take priority over a simultaneous match_valid, which is dropped: acc, seg_cnt, result_index, peak_mag, peak_index <= 0; state <= IDLE; result_valid <= 0; result holds.
REQ-025 If clear coincides with a dump, no result_valid SHALL be produced.

Reset
REQ-026 rst SHALL force state IDLE and set acc, seg_cnt, len_q, result, result_valid, result_index, peak_mag and peak_index to 0.
REQ-027 rst asserted mid-accumulation SHALL discard the partial sum; no result_valid SHALL be issued for it.
REQ-028 rst SHALL have priority over clear and match_valid.

Structure
REQ-029 The shared acquire-engine package SHALL hold MATCH_BITS=31, CNT_W=5, LEN_W=6, ACC_W=12, MAG_W=11, IDX_W=10 and the IDLE/ACCUM state encoding.
REQ-030 Peak comparison and capture SHALL sit in one sub-module, peak_tracker (inputs: result, result_valid, result_index, clear; outputs: peak_mag, peak_index).

Verification
REQ-031 acc_length=0, match_cnt=31 -> result=+31 and result_valid one cycle later; peak_mag=31, peak_index=0, then result_index=1.
REQ-032 acc_length=63, 64 samples of match_cnt=0 -> exactly one result_valid, after the 64th sample; result=-1984, peak_mag=1984.
REQ-033 acc_length=3, samples 20,10,31,0 with idle gaps between them, acc_length changed to 0 after the first sample -> result=-2, emitted after the 4th sample only.
REQ-034 acc_length=3, clear together with the 3rd sample, then 4 samples of 16 -> single result=+4 at result_index=0.
REQ-035 acc_length=0, results +5, -5, +7, -7 -> peak_mag=7, peak_index=2 at the end; result_index=4.
REQ-036 rst asserted after 2 of 4 samples, then 4 samples of 31 -> one result=+124 and all outputs 0 during reset.
